hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding scoreboard for the pipelined MIPS core. It replaces the fixed 5-stage, opcode-decoding forward controller with a generic scoreboard:
- tracks in-flight register writers across `DEPTH` post-decode stages, with per-writer Tnew countdowns;
- compares them against per-operand Tuse of the decode-stage instruction;
- emits stall and forward selects for D-stage and E-stage consumers;
- optionally tracks a multi-cycle mult/div unit.

It sits beside the D/E pipeline registers; decode supplies Tnew/Tuse.

---
 rtl/hazard_scoreboard.sv | 135 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Generic hazard/forwarding scoreboard: DEPTH in-flight writer slots with Tnew countdowns,
// checked against decode-stage Tuse. Define HAZ_MDU_EN to build the mult/div busy counter.
module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int NUM_SRC  = 2,
  parameter int TNEW_W   = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      d_valid,
  input  logic [4:0]                d_dest,
  input  logic [TNEW_W-1:0]         d_tnew,
  input  logic [NUM_SRC*5-1:0]      d_src_addr,
  input  logic [NUM_SRC*TNEW_W-1:0] d_src_tuse,
  input  logic [NUM_SRC-1:0]        d_src_used,
  input  logic                      d_md,
  input  logic                      md_start,
  input  logic                      md_is_div,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  d_fwd_sel,
  output logic [NUM_SRC*SEL_W-1:0]  e_fwd_sel,
  output logic                      md_busy
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        dest;
    logic [TNEW_W-1:0] tnew;
  } slot_t;

  typedef struct packed {
    logic              hit;
    logic [SEL_W-1:0]  sel;
    logic [TNEW_W-1:0] tnew;
  } match_t;

  slot_t                r_slot [1:DEPTH];
  logic [NUM_SRC*5-1:0] r_e_src_addr;
  logic [NUM_SRC-1:0]   r_e_src_used;

  logic [NUM_SRC-1:0]   w_data_stall;
  match_t               w_d_match;
  match_t               w_e_match;
  logic                 w_md_stall;
  logic                 w_insert;

  // Scanning oldest-to-youngest lets the lowest matching slot overwrite older matches.
  function automatic match_t find_youngest(input logic [4:0] addr, input int first);
    match_t m;
    m = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (k >= first && r_slot[k].valid && r_slot[k].dest != 5'd0 && r_slot[k].dest == addr) begin
        m.hit  = 1'b1;
        m.sel  = SEL_W'(k);
        m.tnew = r_slot[k].tnew;
      end
    end
    return m;
  endfunction

  function automatic slot_t advance(input slot_t s);
    slot_t n;
    n = s;
    if (n.tnew != '0) n.tnew = n.tnew - 1'b1;
    return n;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_data_stall = '0;
    d_fwd_sel    = '0;
    e_fwd_sel    = '0;
    w_d_match    = '0;
    w_e_match    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_d_match = find_youngest(d_src_addr[i*5 +: 5], 1);
      if (d_src_used[i] && w_d_match.hit) begin
        if (w_d_match.tnew > d_src_tuse[i*TNEW_W +: TNEW_W]) w_data_stall[i] = 1'b1;
        if (w_d_match.tnew == '0) d_fwd_sel[i*SEL_W +: SEL_W] = w_d_match.sel;
      end
      w_e_match = find_youngest(r_e_src_addr[i*5 +: 5], 2);
      if (r_slot[1].valid && r_e_src_used[i] && w_e_match.hit && w_e_match.tnew == '0)
        e_fwd_sel[i*SEL_W +: SEL_W] = w_e_match.sel;
    end
  end

  assign w_md_stall = d_md & md_busy;
  assign stall      = d_valid & ((|w_data_stall) | w_md_stall);
  assign w_insert   = d_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the slot array is a handful of flops, not a RAM, so every entry is reset.
      for (int k = 1; k <= DEPTH; k++) r_slot[k] <= '0;
      r_e_src_addr <= '0;
      r_e_src_used <= '0;
    end else begin
      // NOTE: non-blocking assignments make the shift order-independent.
      for (int k = 2; k <= DEPTH; k++) r_slot[k] <= advance(r_slot[k-1]);
      if (w_insert) begin
        r_slot[1]    <= '{valid: 1'b1, dest: d_dest, tnew: d_tnew};
        r_e_src_addr <= d_src_addr;
        r_e_src_used <= d_src_used;
      end else begin
        r_slot[1]    <= '0;
        r_e_src_addr <= '0;
        r_e_src_used <= '0;
      end
    end
  end

`ifdef HAZ_MDU_EN
  localparam int LAT_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  logic [CNT_W-1:0] r_md_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             r_md_cnt <= '0;
    else if (md_start)        r_md_cnt <= md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (r_md_cnt != '0)  r_md_cnt <= r_md_cnt - 1'b1;
  end

  assign md_busy = (r_md_cnt != '0) | md_start;
`else
  logic w_unused_md;
  assign w_unused_md = ^{md_start, md_is_div, 32'(MULT_LAT), 32'(DIV_LAT)};
  assign md_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stall, forwarding, shadowing, flush, reset and
// (with HAZ_MDU_EN) mult/div busy timing, against hand-computed expectations.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset_n;
  logic       d_valid;
  logic [4:0] d_dest;
  logic [1:0] d_tnew;
  logic [9:0] d_src_addr;
  logic [3:0] d_src_tuse;
  logic [1:0] d_src_used;
  logic       d_md;
  logic       md_start;
  logic       md_is_div;
  logic       flush;
  logic       stall;
  logic [3:0] d_fwd_sel;
  logic [3:0] e_fwd_sel;
  logic       md_busy;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_valid    (d_valid),
    .d_dest     (d_dest),
    .d_tnew     (d_tnew),
    .d_src_addr (d_src_addr),
    .d_src_tuse (d_src_tuse),
    .d_src_used (d_src_used),
    .d_md       (d_md),
    .md_start   (md_start),
    .md_is_div  (md_is_div),
    .flush      (flush),
    .stall      (stall),
    .d_fwd_sel  (d_fwd_sel),
    .e_fwd_sel  (e_fwd_sel),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the D-stage instruction and let combinational outputs settle.
  task automatic drv(input logic v, input logic [4:0] dst, input logic [1:0] tn,
                     input logic [4:0] a0, input logic [1:0] t0,
                     input logic [4:0] a1, input logic [1:0] t1, input logic [1:0] used);
    d_valid    = v;
    d_dest     = dst;
    d_tnew     = tn;
    d_src_addr = {a1, a0};
    d_src_tuse = {t1, t0};
    d_src_used = used;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    md_start = 1'b0;
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      nop();
    end
  endtask

  initial begin
    reset_n   = 1'b1;
    d_md      = 1'b0;
    md_start  = 1'b0;
    md_is_div = 1'b0;
    flush     = 1'b0;
    nop();
    reset_n = 1'b0;
    #1;
    chk1("rst_stall", stall, 1'b0);
    chk4("rst_dsel", d_fwd_sel, 4'h0);
    chk4("rst_esel", e_fwd_sel, 4'h0);
    chk1("rst_busy", md_busy, 1'b0);
    #9 reset_n = 1'b1;

    // ALU forward: addu $3 (tnew 1) -> beq $3 (tuse 0)
    tick(); drv(1, 5'd3, 2'd1, 5'd1, 2'd1, 5'd2, 2'd1, 2'b11);
    chk1("alu_writer_nostall", stall, 1'b0);
    tick(); drv(1, 5'd0, 2'd0, 5'd3, 2'd0, 5'd0, 2'd0, 2'b11);
    chk1("alu_stall", stall, 1'b1);
    chk4("alu_stall_dsel", d_fwd_sel, 4'h0);
    tick(); flush = 1'b1; drv(1, 5'd0, 2'd0, 5'd3, 2'd0, 5'd0, 2'd0, 2'b11);
    chk1("alu_release", stall, 1'b0);
    chk4("alu_dsel_m", d_fwd_sel, 4'h2);
    tick(); drv(1, 5'd0, 2'd0, 5'd3, 2'd0, 5'd0, 2'd0, 2'b11);
    chk4("alu_dsel_w", d_fwd_sel, 4'h3);
    tick(); nop();
    chk4("alu_e_falloff", e_fwd_sel, 4'h0);
    idle(3);

    // Load-use: lw $5 (tnew 2) -> addu $6,$5,$7 (tuse 1)
    tick(); drv(1, 5'd5, 2'd2, 5'd29, 2'd1, 5'd0, 2'd0, 2'b01);
    tick(); drv(1, 5'd6, 2'd1, 5'd5, 2'd1, 5'd7, 2'd1, 2'b11);
    chk1("lu_stall", stall, 1'b1);
    chk4("lu_stall_dsel", d_fwd_sel, 4'h0);
    tick(); drv(1, 5'd6, 2'd1, 5'd5, 2'd1, 5'd7, 2'd1, 2'b11);
    chk1("lu_one_cycle", stall, 1'b0);
    chk4("lu_dsel_pending", d_fwd_sel, 4'h0);
    tick(); nop();
    chk4("lu_esel_w", e_fwd_sel, 4'h3);
    idle(3);

    // Load-use with tuse 0: two stall cycles, then forward from W
    tick(); drv(1, 5'd5, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
    tick(); drv(1, 5'd9, 2'd1, 5'd5, 2'd0, 5'd0, 2'd0, 2'b01);
    chk1("lu0_stall1", stall, 1'b1);
    tick(); drv(1, 5'd9, 2'd1, 5'd5, 2'd0, 5'd0, 2'd0, 2'b01);
    chk1("lu0_stall2", stall, 1'b1);
    chk4("lu0_stall2_dsel", d_fwd_sel, 4'h0);
    tick(); drv(1, 5'd9, 2'd1, 5'd5, 2'd0, 5'd0, 2'd0, 2'b01);
    chk1("lu0_release", stall, 1'b0);
    chk4("lu0_dsel_w", d_fwd_sel, 4'h3);
    idle(4);

    // Shadowing: addu $4 (tnew 1), ori $4 (tnew 0), reader of $4 (tuse 1)
    tick(); drv(1, 5'd4, 2'd1, 5'd1, 2'd1, 5'd2, 2'd1, 2'b11);
    tick(); drv(1, 5'd4, 2'd0, 5'd8, 2'd1, 5'd0, 2'd0, 2'b01);
    tick(); drv(1, 5'd10, 2'd1, 5'd4, 2'd1, 5'd0, 2'd0, 2'b01);
    chk1("shadow_nostall", stall, 1'b0);
    chk4("shadow_dsel", d_fwd_sel, 4'h1);
    tick(); nop();
    chk4("shadow_esel", e_fwd_sel, 4'h2);
    idle(3);

    // Shadowed stall, flush during the stall
    tick(); drv(1, 5'd4, 2'd0, 5'd1, 2'd1, 5'd2, 2'd1, 2'b11);
    tick(); drv(1, 5'd4, 2'd1, 5'd8, 2'd1, 5'd0, 2'd0, 2'b01);
    tick(); flush = 1'b1; drv(1, 5'd10, 2'd1, 5'd4, 2'd0, 5'd0, 2'd0, 2'b01);
    chk1("shadow_stall", stall, 1'b1);
    chk4("shadow_stall_dsel", d_fwd_sel, 4'h0);
    tick(); drv(1, 5'd10, 2'd1, 5'd4, 2'd0, 5'd0, 2'd0, 2'b01);
    chk1("shadow_release", stall, 1'b0);
    chk4("shadow_release_dsel", d_fwd_sel, 4'h2);
    chk4("flush_stall_slot1_empty", e_fwd_sel, 4'h0);
    idle(4);

    // Flush without stall drops the D instruction
    tick(); flush = 1'b1; drv(1, 5'd11, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
    tick(); drv(1, 5'd12, 2'd1, 5'd11, 2'd0, 5'd0, 2'd0, 2'b01);
    chk1("flush_drop_stall", stall, 1'b0);
    chk4("flush_drop_dsel", d_fwd_sel, 4'h0);
    idle(3);

    // Register $0 never matches
    tick(); drv(1, 5'd0, 2'd2, 5'd1, 2'd1, 5'd2, 2'd1, 2'b11);
    tick(); drv(1, 5'd13, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b11);
    chk1("zero_nostall", stall, 1'b0);
    chk4("zero_dsel", d_fwd_sel, 4'h0);
    idle(3);

    // stall is masked by d_valid
    tick(); drv(1, 5'd14, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
    tick(); drv(0, 5'd15, 2'd1, 5'd14, 2'd0, 5'd0, 2'd0, 2'b01);
    chk1("invalid_mask", stall, 1'b0);
    idle(3);

    // Reset mid-run
    tick(); drv(1, 5'd12, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
    tick(); drv(1, 5'd13, 2'd1, 5'd12, 2'd1, 5'd0, 2'd0, 2'b01);
    tick(); drv(1, 5'd16, 2'd1, 5'd12, 2'd0, 5'd13, 2'd0, 2'b11);
    chk1("pre_rst_stall", stall, 1'b1);
    chk4("pre_rst_dsel", d_fwd_sel, 4'h2);
    chk4("pre_rst_esel", e_fwd_sel, 4'h2);
    reset_n = 1'b0;
    #1;
    chk1("midrst_stall", stall, 1'b0);
    chk4("midrst_dsel", d_fwd_sel, 4'h0);
    chk4("midrst_esel", e_fwd_sel, 4'h0);
    chk1("midrst_busy", md_busy, 1'b0);
    reset_n = 1'b1;
    #1;
    chk1("post_rst_stall", stall, 1'b0);
    chk4("post_rst_regfile", d_fwd_sel, 4'h0);
    idle(3);

`ifdef HAZ_MDU_EN
    // div in E, mfhi waiting in D
    tick();
    chk1("md_idle_before_div", md_busy, 1'b0);
    md_start = 1'b1; md_is_div = 1'b1; d_md = 1'b1;
    drv(1, 5'd14, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
    chk1("div_start_busy", md_busy, 1'b1);
    chk1("div_start_stall", stall, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      tick(); drv(1, 5'd14, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
      chk1("div_busy", md_busy, 1'b1);
      chk1("div_stall", stall, 1'b1);
    end
    tick(); drv(1, 5'd14, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
    chk1("div_release_busy", md_busy, 1'b0);
    chk1("div_release_stall", stall, 1'b0);
    d_md = 1'b0;
    tick(); nop();
    chk1("md_idle_before_mult", md_busy, 1'b0);
    md_start = 1'b1; md_is_div = 1'b0;
    #1;
    chk1("mult_start_busy", md_busy, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick(); nop();
      chk1("mult_busy", md_busy, 1'b1);
    end
    tick(); nop();
    chk1("mult_release", md_busy, 1'b0);
`else
    tick();
    md_start = 1'b1; md_is_div = 1'b1; d_md = 1'b1;
    drv(1, 5'd14, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
    chk1("nomdu_busy", md_busy, 1'b0);
    chk1("nomdu_stall", stall, 1'b0);
    d_md = 1'b0;
    tick(); nop();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
